// File: rtl/button_enable_gen.sv
// button_enable_gen: synchronizes and debounces a raw push-button, emitting one enable pulse per press.
// Define BTN_AUTO_REPEAT_EN to add auto-repeat pulses while the button stays held.
`timescale 1ns/1ps
module button_enable_gen #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_PERIOD   = 10000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic enb_pulse,
    output logic btn_level
);
    // state        | meaning
    // IDLE         | debounced level low, waiting for a high sample
    // PRESS_WAIT   | counting consecutive high samples
    // HELD         | debounced level high
    // RELEASE_WAIT | counting consecutive low samples

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_PERIOD < 1) begin : g_bad_period
        $error("REPEAT_PERIOD must be at least 1");
    end
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES) ||
        (64'd1 << CNT_W) <= 64'(REPEAT_DELAY) ||
        (64'd1 << CNT_W) <= 64'(REPEAT_PERIOD)) begin : g_bad_width
        $error("CNT_W too narrow for the configured cycle counts");
    end

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_s1;
    logic             btn_s;
    state_t           state;
    logic [CNT_W-1:0] cnt;

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_FIRST_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_NEXT_LAST  = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rcnt;
    // set once the first repeat has fired, so later repeats use the shorter period
    logic             rpt_armed;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_s1 <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            btn_s1 <= btn_in;
            btn_s  <= btn_s1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            enb_pulse <= 1'b0;
            btn_level <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            rcnt      <= '0;
            rpt_armed <= 1'b0;
`endif
        end else begin
            enb_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end

                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (cnt == DB_LAST) begin
                        state     <= HELD;
                        enb_pulse <= 1'b1;
                        btn_level <= 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                        rcnt      <= '0;
                        rpt_armed <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                HELD: begin
                    if (!btn_s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
`ifdef BTN_AUTO_REPEAT_EN
                    else if (rcnt == (rpt_armed ? RPT_NEXT_LAST : RPT_FIRST_LAST)) begin
                        enb_pulse <= 1'b1;
                        rcnt      <= '0;
                        rpt_armed <= 1'b1;
                    end else begin
                        rcnt <= rcnt + CNT_W'(1);
                    end
`endif
                end

                RELEASE_WAIT: begin
                    // a bounce back high returns to HELD silently; btn_level never dropped
                    if (btn_s) begin
                        state <= HELD;
`ifdef BTN_AUTO_REPEAT_EN
                        rcnt      <= '0;
                        rpt_armed <= 1'b0;
`endif
                    end else if (cnt == DB_LAST) begin
                        state     <= IDLE;
                        btn_level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_enable_gen.sv
// tb_button_enable_gen: directed and random button stimulus, scoreboarded against a run-length debounce model.
`timescale 1ns/1ps
module tb_button_enable_gen;
    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic enb_pulse;
    logic btn_level;

    always #5 clk = ~clk;

    button_enable_gen #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(8),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_in(btn_in),
        .enb_pulse(enb_pulse),
        .btn_level(btn_level)
    );

    typedef struct {
        logic pulse;
        logic level;
        int   cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests    = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    int   exp_pulses = 0;
    int   dut_pulses = 0;

    // Reference: the debounced level flips once DB+1 consecutive synchronized samples
    // disagree with it; m_age counts uninterrupted high samples since the level was (re)established.
    logic m_s1, m_s2, m_level, m_pulse;
    int   m_run, m_age;
    logic rst_cur, btn_cur;

    function automatic void model_clear();
        m_s1    = 1'b0;
        m_s2    = 1'b0;
        m_level = 1'b0;
        m_pulse = 1'b0;
        m_run   = 0;
        m_age   = 0;
    endfunction

    function automatic void model_edge();
        logic s;
        s    = m_s2;
        m_s2 = m_s1;
        m_s1 = btn_cur;
        if (s != m_level) begin
            m_run++;
            if (m_run == DB + 1) begin
                m_level = s;
                m_run   = 0;
                m_age   = 0;
                m_pulse = s;
            end
        end else if (m_level && m_run != 0) begin
            m_run = 0;
            m_age = 0;
        end else begin
            m_run = 0;
            if (m_level) begin
                m_age++;
`ifdef BTN_AUTO_REPEAT_EN
                if (m_age >= RD && ((m_age - RD) % RP) == 0) m_pulse = 1'b1;
`endif
            end
        end
    endfunction

    task automatic step(input logic b, input logic r);
        @(posedge clk);
        cyc++;
        m_pulse = 1'b0;
        if (rst_cur) model_edge();
        #2;
        btn_in  = b;
        reset   = r;
        btn_cur = b;
        rst_cur = r;
        if (!r) model_clear();
        if (m_pulse) exp_pulses++;
        exp_q.push_back('{m_pulse, m_level, cyc});
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (enb_pulse !== e.pulse) begin
                    n_fail++;
                    $display("FAIL enb_pulse cycle %0d: got %b, expected %b", e.cyc, enb_pulse, e.pulse);
                end
                n_tests++;
                if (btn_level !== e.level) begin
                    n_fail++;
                    $display("FAIL btn_level cycle %0d: got %b, expected %b", e.cyc, btn_level, e.level);
                end
                if (enb_pulse === 1'b1) dut_pulses++;
            end
        end
    end

    initial begin : stimulus
        int kind;
        int len;
        reset   = 1'b0;
        btn_in  = 1'b0;
        rst_cur = 1'b0;
        btn_cur = 1'b0;
        model_clear();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        hold(1'b0, 4);

        // clean press held long enough to exercise auto-repeat, then clean release
        hold(1'b1, 32);
        hold(1'b0, 12);

        // press bounce 1,1,0,1,1,0
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
            step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
        end
        hold(1'b0, 10);

        // release bounce from HELD
        hold(1'b1, 12);
        hold(1'b0, 2);
        hold(1'b1, 12);
        hold(1'b0, 12);

        // reset in the middle of a press, button still held afterwards
        hold(1'b1, 4);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        hold(1'b1, 14);
        hold(1'b0, 12);

        // reset while held
        hold(1'b1, 12);
        step(1'b1, 1'b0);
        hold(1'b1, 12);
        hold(1'b0, 12);

        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 4) begin
                hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 30)));
            end else if (kind < 8) begin
                len = int'($urandom_range(1, 12));
                for (int j = 0; j < len; j++) step(1'($urandom_range(0, 1)), 1'b1);
            end else begin
                len = int'($urandom_range(1, 3));
                for (int j = 0; j < len; j++) step(1'($urandom_range(0, 1)), 1'b0);
            end
        end
        hold(1'b0, 15);

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        n_tests++;
        if (dut_pulses != exp_pulses) begin
            n_fail++;
            $display("FAIL pulse_total: got %0d, expected %0d", dut_pulses, exp_pulses);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
